// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: operation and burst-state encodings.
// No logic here, so no latency or backpressure of its own.
package shreg_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5,
    CLR  = 3'd6,
    SET  = 3'd7
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Only these ops are worth repeating; everything else is idempotent after one step.
  function automatic logic is_shift(mode_e m);
    return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR);
  endfunction

endpackage

// File: rtl/shreg_step.sv
// One step of a register op, purely combinational (zero latency).
// Has no flow control; the caller decides whether to commit q_next.
module shreg_step
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            op,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      HOLD:    q_next = q;
      LOAD:    q_next = d;
      SHL:     q_next = {q[WIDTH-2:0], sin_r};
      SHR:     q_next = {sin_l, q[WIDTH-1:1]};
      ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      ROR:     q_next = {q[0], q[WIDTH-1:1]};
      CLR:     q_next = '0;
      SET:     q_next = '1;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register with single-step ops and a multi-cycle shift/rotate burst (one step per edge).
// A burst of N steps takes N edges; en low stalls it in place, and done pulses once per start.
module univ_shift_reg
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  state_e           state, state_nxt;
  mode_e            op_r, op_nxt;
  mode_e            mode_in, op_sel;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] q_r, q_nxt, step_q;
  logic             done_r, done_nxt;

  assign mode_in = mode_e'(mode);
  // The burst replays the latched op so mode may change freely while RUN.
  assign op_sel  = (state == RUN) ? op_r : mode_in;

  shreg_step #(.WIDTH(WIDTH)) u_step (
    .q      (q_r),
    .op     (op_sel),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .d      (d),
    .q_next (step_q)
  );

  always_comb begin
    state_nxt = state;
    op_nxt    = op_r;
    cnt_nxt   = cnt;
    q_nxt     = q_r;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          q_nxt = step_q;
          if (start) begin
            if (is_shift(mode_in) && (shamt >= SHW'(2))) begin
              op_nxt    = mode_in;
              cnt_nxt   = shamt - SHW'(1);
              state_nxt = RUN;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
      end
      RUN: begin
        if (en) begin
          q_nxt   = step_q;
          cnt_nxt = cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= HOLD;
      cnt    <= '0;
      q_r    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      op_r   <= op_nxt;
      cnt    <= cnt_nxt;
      q_r    <= q_nxt;
      done_r <= done_nxt;
    end
  end

  assign q      = q_r;
  assign sout_l = q_r[WIDTH-1];
  assign sout_r = q_r[0];
  assign busy   = (state == RUN);
  assign done   = done_r;

endmodule
